// File: rtl/pmod_adc_pkg.sv
// Shared types and default geometry for the PMOD ADC sampler.
package pmod_adc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam int unsigned DEF_CLK_DIV     = 4;
  localparam int unsigned DEF_FRAME_BITS  = 16;
  localparam int unsigned DEF_SAMPLE_BITS = 12;
  localparam int unsigned DEF_CS_SETUP    = 2;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider for the sampler: high/low phases of CLK_DIV cycles, a sample
// strobe on the last high cycle, and a frame-done strobe after the final pulse.
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned TAIL       = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  output logic sclk,
  output logic sample_stb,
  output logic frame_done
);

  logic [15:0] div_cnt;
  logic [15:0] bit_cnt;
  logic        phase;     // 0 = high phase, 1 = low phase
  logic        last_bit;
  logic        term;

  // The final low phase is shortened to TAIL so csb rises TAIL cycles after the last fall.
  always_comb begin
    last_bit = (bit_cnt == 16'(FRAME_BITS - 1));
    if (phase && last_bit) term = (div_cnt == 16'(TAIL - 1));
    else                   term = (div_cnt == 16'(CLK_DIV - 1));
  end

  assign sclk       = run & ~phase;
  assign sample_stb = run & ~phase & term;
  assign frame_done = run & phase & last_bit & term;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      phase   <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      phase   <= 1'b0;
    end else if (term) begin
      div_cnt <= '0;
      phase   <= ~phase;
      if (phase) bit_cnt <= bit_cnt + 16'd1;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/pmod_adc_sampler.sv
// SPI master and conversion scheduler for a PMOD ADC (single-shot or periodic).
// Define ADC_SAMPLER_THRESH_EN to add a threshold port gating the interrupt.
module pmod_adc_sampler
  import pmod_adc_pkg::*;
#(
  parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
  parameter int unsigned FRAME_BITS  = DEF_FRAME_BITS,
  parameter int unsigned SAMPLE_BITS = DEF_SAMPLE_BITS,
  parameter int unsigned CS_SETUP    = DEF_CS_SETUP
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic                   start,
  input  logic                   continuous,
  input  logic [15:0]            period,
  input  logic                   irq_ack,
`ifdef ADC_SAMPLER_THRESH_EN
  input  logic [SAMPLE_BITS-1:0] threshold,
`endif
  output logic                   spi_csb,
  output logic                   spi_sclk,
  output logic                   spi_sdo,
  input  logic                   spi_sdi,
  output logic [FRAME_BITS-1:0]  raw_frame,
  output logic [SAMPLE_BITS-1:0] sample,
  output logic                   sample_valid,
  output logic                   busy,
  output logic                   irq,
  output logic                   overrun
);

  state_t                state, state_n;
  logic [15:0]           ph_cnt;
  logic [15:0]           per_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  shifting;
  logic                  cs_active;
  logic                  sample_stb;
  logic                  frame_done;
  logic                  ph_last;
  logic                  period_due;
  logic                  commit;
  logic                  irq_hit;

  assign shifting = (state == SHIFT);

  spi_sclk_gen #(
    .CLK_DIV   (CLK_DIV),
    .FRAME_BITS(FRAME_BITS),
    .TAIL      (CS_SETUP)
  ) u_sclk_gen (
    .clk       (clk),
    .resetn    (resetn),
    .run       (shifting),
    .sclk      (spi_sclk),
    .sample_stb(sample_stb),
    .frame_done(frame_done)
  );

  // per_cnt is 0 on the csb-fall cycle, so expiry is one cycle before it reaches period.
  always_comb begin
    ph_last    = (ph_cnt == 16'(CS_SETUP - 1));
    period_due = (({1'b0, per_cnt} + 17'd1) >= {1'b0, period});
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start) state_n = SETUP;
      SETUP: if (ph_last) state_n = SHIFT;
      SHIFT: if (frame_done) state_n = HOLD;
      HOLD: begin
        if (ph_last) begin
          if (!continuous)     state_n = IDLE;
          else if (period_due) state_n = SETUP;
          else                 state_n = GAP;
        end
      end
      GAP: begin
        if (!continuous)     state_n = IDLE;
        else if (period_due) state_n = SETUP;
      end
      default: state_n = IDLE;
    endcase
    if (!enable) state_n = IDLE;
  end

  always_comb begin
    cs_active = (state == SETUP) || (state == SHIFT);
    commit    = (state == SHIFT) && (state_n == HOLD);
`ifdef ADC_SAMPLER_THRESH_EN
    irq_hit   = (shreg[SAMPLE_BITS-1:0] >= threshold);
`else
    irq_hit   = 1'b1;
`endif
  end

  assign spi_csb = ~cs_active;
  assign busy    = cs_active;
  assign spi_sdo = 1'b0;
  assign sample  = raw_frame[SAMPLE_BITS-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ph_cnt  <= '0;
      per_cnt <= '0;
    end else begin
      if (state_n != state)                    ph_cnt <= '0;
      else if (state == SETUP || state == HOLD) ph_cnt <= ph_cnt + 16'd1;

      if (state_n == SETUP && state != SETUP) per_cnt <= '0;
      else if (state != IDLE)                 per_cnt <= per_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shreg        <= '0;
      raw_frame    <= '0;
      sample_valid <= 1'b0;
    end else begin
      if (sample_stb) shreg <= {shreg[FRAME_BITS-2:0], spi_sdi};
      sample_valid <= commit;
      if (commit) raw_frame <= shreg;
    end
  end

  // Set has priority over a same-cycle acknowledge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (commit && irq_hit) irq <= 1'b1;
      else if (irq_ack)      irq <= 1'b0;

      if (start && cs_active) overrun <= 1'b1;
      else if (irq_ack)       overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pmod_adc_sampler.sv
// Self-checking bench for pmod_adc_sampler with an ADC model returning 3*n on the n-th frame.
module tb_pmod_adc_sampler;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CS_SETUP   = 2;
  localparam int unsigned FRAME_LEN  = 3*CS_SETUP + (FRAME_BITS-1)*2*CLK_DIV + CLK_DIV;
  localparam int unsigned LOW_LEN    = FRAME_LEN - CS_SETUP;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [15:0] period = '0;
  logic        irq_ack = 1'b0;
`ifdef ADC_SAMPLER_THRESH_EN
  logic [11:0] threshold = '0;
`endif
  logic        spi_csb, spi_sclk, spi_sdo, spi_sdi;
  logic [15:0] raw_frame;
  logic [11:0] sample;
  logic        sample_valid, busy, irq, overrun;

  pmod_adc_sampler dut (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (enable),
    .start       (start),
    .continuous  (continuous),
    .period      (period),
    .irq_ack     (irq_ack),
`ifdef ADC_SAMPLER_THRESH_EN
    .threshold   (threshold),
`endif
    .spi_csb     (spi_csb),
    .spi_sclk    (spi_sclk),
    .spi_sdo     (spi_sdo),
    .spi_sdi     (spi_sdi),
    .raw_frame   (raw_frame),
    .sample      (sample),
    .sample_valid(sample_valid),
    .busy        (busy),
    .irq         (irq),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // ADC model: load 3*n at each csb fall, present MSB first, advance on sclk fall.
  logic [15:0] adc_sh = '0;
  int unsigned adc_k = 0;
  logic        csb_m = 1'b1;
  always @(spi_csb or negedge spi_sclk) begin
    if (!spi_csb && csb_m) begin
      adc_sh <= 16'(adc_k * 3);
      adc_k  <= adc_k + 1;
    end else if (!spi_csb && !csb_m) begin
      adc_sh <= adc_sh << 1;
    end
    csb_m <= spi_csb;
  end
  assign spi_sdi = adc_sh[15];

  // Bus monitor sampled mid-cycle.
  int unsigned ncyc = 0, pulses = 0, frame_pulses = 0, nvalid = 0;
  int unsigned last_fall_cyc = 0, csb_rise_cyc = 0, sclk_fall_cyc = 0, first_rise_off = 0;
  logic        csb_q = 1'b1, sclk_q = 1'b0;
  int unsigned falls[$];
  logic [15:0] frames[$];
  always @(negedge clk) begin
    ncyc   <= ncyc + 1;
    csb_q  <= spi_csb;
    sclk_q <= spi_sclk;
    if (csb_q && !spi_csb) begin
      falls.push_back(ncyc);
      last_fall_cyc <= ncyc;
      frame_pulses  <= 0;
    end
    if (!csb_q && spi_csb) csb_rise_cyc <= ncyc;
    if (!sclk_q && spi_sclk) begin
      pulses       <= pulses + 1;
      frame_pulses <= frame_pulses + 1;
      if (frame_pulses == 0) first_rise_off <= ncyc - last_fall_cyc;
    end
    if (sclk_q && !spi_sclk) sclk_fall_cyc <= ncyc;
    if (sample_valid) begin
      frames.push_back(raw_frame);
      nvalid <= nvalid + 1;
    end
  end

  int unsigned tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
  endtask

  task automatic wait_valid(input int unsigned target, input int unsigned budget, input string name);
    int unsigned n = 0;
    while (nvalid < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(nvalid >= target), 32'd1);
  endtask

  task automatic wait_pulses(input int unsigned target, input int unsigned budget, input string name);
    int unsigned n = 0;
    while (pulses < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(pulses >= target), 32'd1);
  endtask

  typedef struct {
    logic [15:0] period;
    int unsigned exp_gap;
  } cvec_t;

  cvec_t       vecs[10];
  int unsigned k0, v0, p0;

  initial begin
    vecs[0] = '{16'd200, 200};
    vecs[1] = '{16'd130, 130};
    vecs[2] = '{16'd129, 130};
    vecs[3] = '{16'd0,   130};
    vecs[4] = '{16'd131, 131};
    vecs[5] = '{16'd300, 300};
    for (int i = 6; i < 10; i++) begin
      p0 = $urandom_range(90, 260);
      vecs[i] = '{16'(p0), (p0 > FRAME_LEN) ? p0 : FRAME_LEN};
    end

    // Reset state
    tick(3);
    check("rst_csb",     32'(spi_csb), 32'd1);
    check("rst_sclk",    32'(spi_sclk), 32'd0);
    check("rst_sdo",     32'(spi_sdo), 32'd0);
    check("rst_raw",     32'(raw_frame), 32'd0);
    check("rst_sample",  32'(sample), 32'd0);
    check("rst_valid",   32'(sample_valid), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_irq",     32'(irq), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    resetn = 1'b1;
    enable = 1'b1;
    tick(3);

    // Single conversion: frame timing and first sample
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_csb",  32'(spi_csb), 32'd0);
    wait_valid(1, 400, "t1_done");
    tick(10);
    check("t1_falls",   32'(falls.size()), 32'd1);
    check("t1_pulses",  32'(frame_pulses), 32'(FRAME_BITS));
    check("t1_setup",   32'(first_rise_off), 32'(CS_SETUP));
    check("t1_tail",    32'(csb_rise_cyc - sclk_fall_cyc), 32'(CS_SETUP));
    check("t1_lowlen",  32'(csb_rise_cyc - last_fall_cyc), 32'(LOW_LEN));
    check("t1_frame",   32'(frames[0]), 32'h0000);
    check("t1_sample",  32'(sample), 32'h000);
    check("t1_nvalid",  32'(nvalid), 32'd1);
    check("t1_irq",     32'(irq), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);

    // Ack then second conversion
    ack();
    check("t2_irq_clr", 32'(irq), 32'd0);
    v0 = nvalid;
    pulse_start();
    wait_valid(v0 + 1, 400, "t2_done");
    tick(4);
    check("t2_sample", 32'(sample), 32'h003);
    check("t2_irq",    32'(irq), 32'd1);
    ack();
    check("t2_irq_ack", 32'(irq), 32'd0);

    // Continuous at period 200: three frames
    k0 = falls.size();
    v0 = nvalid;
    period = 16'd200;
    continuous = 1'b1;
    pulse_start();
    wait_valid(v0 + 3, 1200, "t3_done");
    continuous = 1'b0;
    tick(400);
    check("t3_falls", 32'(falls.size() - k0), 32'd3);
    check("t3_gap0",  32'(falls[k0+1] - falls[k0]), 32'd200);
    check("t3_gap1",  32'(falls[k0+2] - falls[k0+1]), 32'd200);
    check("t3_s0",    32'(frames[v0]),   32'h0006);
    check("t3_s1",    32'(frames[v0+1]), 32'h0009);
    check("t3_s2",    32'(frames[v0+2]), 32'h000C);
    ack();

    // Start while shifting: overrun, no extra conversion
    k0 = falls.size();
    v0 = nvalid;
    pulse_start();
    tick(50);
    check("t4_busy", 32'(busy), 32'd1);
    pulse_start();
    check("t4_overrun", 32'(overrun), 32'd1);
    wait_valid(v0 + 1, 400, "t4_done");
    tick(200);
    check("t4_falls",  32'(falls.size() - k0), 32'd1);
    check("t4_nvalid", 32'(nvalid - v0), 32'd1);
    check("t4_sample", 32'(sample), 32'h00F);

    // Abort at the 8th sclk pulse
    k0 = falls.size();
    v0 = nvalid;
    p0 = pulses;
    pulse_start();
    wait_pulses(p0 + 8, 300, "t5_pulses");
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("t5_csb",  32'(spi_csb), 32'd1);
    check("t5_sclk", 32'(spi_sclk), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    tick(200);
    check("t5_novalid", 32'(nvalid - v0), 32'd0);
    check("t5_irq_kept", 32'(irq), 32'd1);
    check("t5_ovr_kept", 32'(overrun), 32'd1);
    ack();
    check("t5_irq_clr", 32'(irq), 32'd0);
    check("t5_ovr_clr", 32'(overrun), 32'd0);
    enable = 1'b1;
    tick(2);
    pulse_start();
    wait_valid(v0 + 1, 400, "t5_done");
    tick(4);
    check("t5_next", 32'(sample), 32'h015);
    ack();

    // Ack on the same edge the frame commits: set wins
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(LOW_LEN - 1);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    check("t6_valid", 32'(sample_valid), 32'd1);
    check("t6_irq",   32'(irq), 32'd1);
    check("t6_sample", 32'(sample), 32'h018);
    tick(10);
    ack();

`ifdef ADC_SAMPLER_THRESH_EN
    // Threshold just above, then equal to, the next sample
    k0 = falls.size();
    v0 = nvalid;
    threshold = 12'(3*k0 + 1);
    pulse_start();
    wait_valid(v0 + 1, 400, "t7_done0");
    tick(4);
    check("t7_below_valid", 32'(nvalid - v0), 32'd1);
    check("t7_below_irq",   32'(irq), 32'd0);
    threshold = 12'(3*(k0 + 1));
    pulse_start();
    wait_valid(v0 + 2, 400, "t7_done1");
    tick(4);
    check("t7_equal_irq", 32'(irq), 32'd1);
    ack();
    threshold = '0;
`endif

    // Continuous-mode spacing table with randomised periods
    for (int i = 0; i < 10; i++) begin
      k0 = falls.size();
      v0 = nvalid;
      period = vecs[i].period;
      continuous = 1'b1;
      tick($urandom_range(1, 20));
      pulse_start();
      wait_valid(v0 + 2, 1500, "cont_done");
      continuous = 1'b0;
      tick(400);
      check("cont_frames", 32'(falls.size() - k0), 32'd2);
      check("cont_gap",    32'(falls[k0+1] - falls[k0]), 32'(vecs[i].exp_gap));
      check("cont_s0",     32'(frames[v0]),   32'(16'(3*k0)));
      check("cont_s1",     32'(frames[v0+1]), 32'(16'(3*(k0+1))));
    end

    // Asynchronous reset mid-frame
    pulse_start();
    tick(40);
    #2 resetn = 1'b0;
    #1;
    check("arst_csb",  32'(spi_csb), 32'd1);
    check("arst_sclk", 32'(spi_sclk), 32'd0);
    check("arst_raw",  32'(raw_frame), 32'd0);
    check("arst_irq",  32'(irq), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    tick(2);
    resetn = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
